// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//   Multi-cycle control sequencer for an RV32I-subset datapath (add, sub, and,
//   or, addi, andi, ori, lw, sw, beq, all-zero NOP). Steps each instruction
//   through fetch / decode / execute / memory / writeback and drives every mux
//   select and write enable of a shared-memory multi-cycle datapath.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   opcode/funct3/funct7_5 fields of the held instruction register
//   zero                  ALU zero flag (qualifies the beq PC load)
//   mem_ready             memory completed the current access this cycle
//   pc_write, ir_write    PC / IR+oldPC load enables
//   adr_src               memory address select (0 PC, 1 ALUOut)
//   mem_read, mem_write   memory access requests
//   reg_write             register file write enable
//   alu_src_a/b, alu_ctrl ALU operand selects and operation
//   result_src            result mux select
//   imm_src               immediate format, combinational from opcode
//   illegal               sticky illegal-instruction flag
//   state                 current state (debug)
//   retired               retired-instruction count, wraps
//
// Memory handshake: a request (mem_read in FETCH/MEMREAD, mem_write in
// MEMWRITE) is held steady until the cycle in which mem_ready is 1; that cycle
// completes the access and the FSM advances on the following edge. mem_ready
// is ignored in every state that does not access memory.
// -----------------------------------------------------------------------------
module mc_control_fsm #(
  parameter int CNT_W    = 32,
  parameter bit NOP_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_ILLEGAL  = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       state_q, state_d;
  logic             retire;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             funct_ok;
  logic [2:0]       alu_funct;

  // Raw (ungated) enables from the state decode.
  logic pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;

  // funct3 values shared by the R-type and I-type ALU groups.
  assign funct_ok = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110);

  // Only register-register ops may select sub; addi ignores instr[30].
  always_comb begin
    alu_funct = ALU_ADD;
    case (funct3)
      3'b000:  alu_funct = ((state_q == S_EXECR) && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_funct = ALU_AND;
      3'b110:  alu_funct = ALU_OR;
      default: alu_funct = ALU_ADD;
    endcase
  end

  // Next-state logic; retire marks the last cycle of a completed instruction.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_ILLEGAL;
        if ((opcode == OP_LOAD) && (funct3 == 3'b010))
          state_d = S_MEMADR;
        else if ((opcode == OP_STORE) && (funct3 == 3'b010))
          state_d = S_MEMADR;
        else if ((opcode == OP_RTYPE) && funct_ok)
          state_d = S_EXECR;
        else if ((opcode == OP_ITYPE) && funct_ok)
          state_d = S_EXECI;
        else if ((opcode == OP_BRANCH) && (funct3 == 3'b000))
          state_d = S_BEQ;
        else if (NOP_ZERO && (opcode == OP_NOP)) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      // Only lw and sw reach MEMADR, so the opcode alone picks the direction.
      S_MEMADR:  state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB, S_BEQ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_ILLEGAL;
    endcase
  end

  // Moore output decode (mem_ready gates the fetch loads, zero gates beq).
  always_comb begin
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_ctrl    = ALU_ADD;
    result_src  = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write_c = mem_ready;
        ir_write_c = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        mem_read_c = 1'b1;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_ctrl  = alu_funct;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_funct;
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_SUB;
        pc_write_c = zero;
      end
      default: ;
    endcase
  end

  // Reset kills every enable combinationally so an in-flight memory access
  // is abandoned at once rather than at the next edge.
  assign pc_write  = pc_write_c  & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign mem_read  = mem_read_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign reg_write = reg_write_c & rst_n;

  always_comb begin
    imm_src = 2'b00;
    case (opcode)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      default:   imm_src = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_ONE;
      if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  localparam int K_NOP = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_ILL = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0]  alu_ctrl;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] retired;

  logic        pc_write_4, ir_write_4, adr_src_4, mem_read_4, mem_write_4, reg_write_4;
  logic [1:0]  alu_src_a_4, alu_src_b_4, result_src_4, imm_src_4;
  logic [2:0]  alu_ctrl_4;
  logic        illegal_4;
  logic [3:0]  state_4;
  logic [3:0]  retired_4;

  mc_control_fsm #(.CNT_W(32), .NOP_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .result_src(result_src), .imm_src(imm_src), .illegal(illegal), .state(state),
    .retired(retired)
  );

  // Narrow-counter instance on the same stimulus, for the wrap check.
  mc_control_fsm #(.CNT_W(4), .NOP_ZERO(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write_4), .ir_write(ir_write_4),
    .adr_src(adr_src_4), .mem_read(mem_read_4), .mem_write(mem_write_4),
    .reg_write(reg_write_4), .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4),
    .alu_ctrl(alu_ctrl_4), .result_src(result_src_4), .imm_src(imm_src_4),
    .illegal(illegal_4), .state(state_4), .retired(retired_4)
  );

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  logic [21:0] obs_q[$];
  int exp_ret = 0;
  int n_checks = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  function automatic int kind_of(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic       alu3;
    op   = w[6:0];
    f3   = w[14:12];
    alu3 = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110);
    if (w[6:0] == 7'b0000000)                    return K_NOP;
    if (op == 7'b0110011 && alu3)                return K_R;
    if (op == 7'b0010011 && alu3)                return K_I;
    if (op == 7'b0000011 && f3 == 3'b010)        return K_LW;
    if (op == 7'b0100011 && f3 == 3'b010)        return K_SW;
    if (op == 7'b1100011 && f3 == 3'b000)        return K_BEQ;
    return K_ILL;
  endfunction

  // ALU operation the instruction asks for in its execute step.
  function automatic logic [2:0] alu_of(input logic [31:0] w);
    case (w[14:12])
      3'b000:  return (w[6:0] == 7'b0110011 && w[30]) ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  // Expected output vector for one cycle in step st of the instruction w.
  function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic mr,
                                          input logic z, input logic [31:0] w);
    logic pcw, irw, adr, mrd, mwr, rw, ill;
    logic [1:0] a, b, rs, imm;
    logic [2:0] alu;
    {pcw, irw, adr, mrd, mwr, rw, ill} = '0;
    a = 2'b00; b = 2'b00; rs = 2'b00; alu = 3'b000;
    case (st)
      4'd0:  begin pcw = mr; irw = mr; mrd = 1'b1; b = 2'b10; rs = 2'b10; end
      4'd1:  begin a = 2'b01; b = 2'b01; end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  begin adr = 1'b1; mrd = 1'b1; end
      4'd4:  begin rs = 2'b01; rw = 1'b1; end
      4'd5:  begin adr = 1'b1; mwr = 1'b1; end
      4'd6:  begin a = 2'b10; b = 2'b00; alu = alu_of(w); end
      4'd7:  begin a = 2'b10; b = 2'b01; alu = alu_of(w); end
      4'd8:  begin rs = 2'b00; rw = 1'b1; end
      4'd9:  begin a = 2'b10; alu = 3'b001; pcw = z; end
      4'd10: ill = 1'b1;
      default: ;
    endcase
    if (w[6:0] == 7'b0100011)      imm = 2'b01;
    else if (w[6:0] == 7'b1100011) imm = 2'b10;
    else                           imm = 2'b00;
    return {st, pcw, irw, adr, mrd, mwr, rw, a, b, alu, rs, imm, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [2:0]  f3s[3];
    int k;
    f3s = '{3'b000, 3'b111, 3'b110};
    w = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      K_NOP: w = 32'h0;
      K_R:   begin w[6:0] = 7'b0110011; w[14:12] = f3s[$urandom_range(0, 2)]; end
      K_I:   begin w[6:0] = 7'b0010011; w[14:12] = f3s[$urandom_range(0, 2)]; end
      K_LW:  begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
      K_SW:  begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
      default: begin w[6:0] = 7'b1100011; w[14:12] = 3'b000; end
    endcase
    return w;
  endfunction

  // ---------------- driver ----------------
  // Plays one instruction: fs fetch stalls, ms memory stalls, zs = zero in
  // the branch step (2 = random). Records expected/observed per cycle and
  // returns just after the edge that completes the instruction.
  task automatic play(input logic [31:0] w, input int fs, input int ms, input int zs);
    logic [3:0] sp[$];
    int mp[$];
    int k;
    logic mr, z;
    k = kind_of(w);
    for (int i = 0; i < fs; i++) begin sp.push_back(4'd0); mp.push_back(0); end
    sp.push_back(4'd0); mp.push_back(1);
    sp.push_back(4'd1); mp.push_back(2);
    case (k)
      K_R:   begin sp.push_back(4'd6); mp.push_back(2); sp.push_back(4'd8); mp.push_back(2); end
      K_I:   begin sp.push_back(4'd7); mp.push_back(2); sp.push_back(4'd8); mp.push_back(2); end
      K_LW: begin
        sp.push_back(4'd2); mp.push_back(2);
        for (int i = 0; i < ms; i++) begin sp.push_back(4'd3); mp.push_back(0); end
        sp.push_back(4'd3); mp.push_back(1);
        sp.push_back(4'd4); mp.push_back(2);
      end
      K_SW: begin
        sp.push_back(4'd2); mp.push_back(2);
        for (int i = 0; i < ms; i++) begin sp.push_back(4'd5); mp.push_back(0); end
        sp.push_back(4'd5); mp.push_back(1);
      end
      K_BEQ: begin sp.push_back(4'd9); mp.push_back(2); end
      K_ILL: for (int i = 0; i < 20; i++) begin sp.push_back(4'd10); mp.push_back(2); end
      default: ;
    endcase
    opcode   = w[6:0];
    funct3   = w[14:12];
    funct7_5 = w[30];
    for (int i = 0; i < sp.size(); i++) begin
      @(negedge clk);
      mr = (mp[i] == 2) ? 1'($urandom_range(0, 1)) : (mp[i] == 1);
      z  = (sp[i] == 4'd9 && zs != 2) ? (zs == 1) : 1'($urandom_range(0, 1));
      mem_ready = mr;
      zero = z;
      #1;
      exp_q.push_back(exp_vec(sp[i], mr, z, w));
      obs_q.push_back({state, pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                       alu_src_a, alu_src_b, alu_ctrl, result_src, imm_src, illegal});
    end
    if (k != K_ILL) exp_ret++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    mem_ready = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pc_write, ir_write, mem_read, mem_write, reg_write} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_enables: got %b expected 00000", {pc_write, ir_write, mem_read, mem_write, reg_write});
    end
    n_checks++;
    if ({state, illegal, retired} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: state %0d illegal %b retired %0d expected 0 0 0", state, illegal, retired);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    exp_ret = 0;
  endtask

  task automatic test_add();
    logic [21:0] e, o;
    do_reset();
    play(32'h019806B3, 0, 0, 2);
    n_checks++;
    if (exp_q.size() != 4) begin n_fail++; $display("FAIL add_len: got %0d expected 4", exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL add_cycle: got %h expected %h", o, e); end
    end
    n_checks++;
    if (retired !== 32'(exp_ret)) begin n_fail++; $display("FAIL add_retired: got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_sub_beq();
    logic [21:0] e, o;
    do_reset();
    play(32'h403402B3, 0, 0, 2);
    play(32'h00948663, 1, 0, 1);
    play(32'h00948663, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL sub_beq_cycle: got %h expected %h", o, e); end
    end
    n_checks++;
    if (retired !== 32'd3) begin n_fail++; $display("FAIL sub_beq_retired: got %0d expected 3", retired); end
  endtask

  task automatic test_lw_stall();
    logic [21:0] e, o;
    play(32'h01F2A403, 0, 3, 2);
    n_checks++;
    if (exp_q.size() != 8) begin n_fail++; $display("FAIL lw_len: got %0d expected 8", exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL lw_cycle: got %h expected %h", o, e); end
    end
    n_checks++;
    if (retired !== 32'(exp_ret)) begin n_fail++; $display("FAIL lw_retired: got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_sw_reset();
    logic [21:0] e, o;
    do_reset();
    play(32'h00000000, 0, 0, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL sw_nop_cycle: got %h expected %h", o, e); end
    end
    opcode = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0;
    @(negedge clk) mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk) mem_ready = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd5 || mem_write !== 1'b1 || retired !== 32'd1) begin
      n_fail++;
      $display("FAIL sw_in_memwrite: state %0d mem_write %b retired %0d expected 5 1 1", state, mem_write, retired);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0 || reg_write !== 1'b0 || state !== 4'd0 || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL sw_reset_abort: mem_write %b mem_read %b reg_write %b state %0d retired %0d expected 0 0 0 0 0",
               mem_write, mem_read, reg_write, state, retired);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 0;
  endtask

  task automatic test_nop_illegal();
    logic [21:0] e, o;
    do_reset();
    play(32'h00000000, 0, 0, 2);
    n_checks++;
    if (exp_q.size() != 2 || retired !== 32'd1) begin
      n_fail++; $display("FAIL nop_len_retired: len %0d retired %0d expected 2 1", exp_q.size(), retired);
    end
    play(32'h0000007F, 0, 0, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL nop_illegal_cycle: got %h expected %h", o, e); end
    end
    n_checks++;
    if (retired !== 32'd1) begin n_fail++; $display("FAIL illegal_retired: got %0d expected 1", retired); end
    do_reset();
    #1;
    n_checks++;
    if (illegal !== 1'b0 || state !== 4'd0) begin
      n_fail++; $display("FAIL illegal_clear: illegal %b state %0d expected 0 0", illegal, state);
    end
  endtask

  task automatic test_illegal_funct();
    logic [21:0] e, o;
    logic [31:0] words[6];
    logic [6:0]  op;
    words[0] = 32'h0198_16B3;          // R-type funct3=001
    words[1] = 32'h0012_A093;          // I-type funct3=010
    words[2] = 32'h01F2_8403;          // load funct3=000
    words[3] = 32'h00F2_8623;          // store funct3=000
    words[4] = 32'h0094_9663;          // branch funct3=001
    do op = 7'($urandom);
    while (op == 7'b0 || op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
           op == 7'b0100011 || op == 7'b1100011);
    words[5] = {25'($urandom), op};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      play(words[i], $urandom_range(0, 2), 0, 2);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL illegal_funct_%0d: got %h expected %h", i, o, e); end
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [21:0] e, o;
    do_reset();
    for (int i = 0; i < 40; i++)
      play(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL random_cycle: got %h expected %h", o, e); end
    end
    n_checks++;
    if (retired !== 32'(exp_ret)) begin n_fail++; $display("FAIL random_retired: got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) play(32'h00000000, $urandom_range(0, 1), 0, 2);
    exp_q.delete();
    obs_q.delete();
    n_checks++;
    if (retired_4 !== 4'(exp_ret)) begin n_fail++; $display("FAIL wrap_cnt4: got %0d expected %0d", retired_4, exp_ret % 16); end
    n_checks++;
    if (retired !== 32'(exp_ret)) begin n_fail++; $display("FAIL wrap_cnt32: got %0d expected %0d", retired, exp_ret); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_beq();
    test_lw_stall();
    test_sw_reset();
    test_nop_illegal();
    test_illegal_funct();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control sequencer for the RV32I subset datapath: add, sub, and, or, addi, andi, ori, lw, sw, beq, plus all-zero NOP.
- Sits between the instruction register and the shared-memory multi-cycle datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback, and drives every mux select and write enable.
- Waits on a memory ready handshake, flags illegal instructions, and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
NOP_ZERO, 1, 1: opcode 7'b0000000 is a NOP; 0: it is illegal

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12]
funct7_5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current access this cycle
pc_write  out  1  PC register load enable
ir_write  out  1  instruction/oldPC register load enable
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write enable
alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or
result_src  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result
imm_src  out  2  00 = I, 01 = S, 10 = B; combinational from opcode
illegal  out  1  sticky illegal-instruction flag
state  out  4  current state, for debug
retired  out  CNT_W  retired-instruction count

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
  - On rst_n=0: state=FETCH(0), retired=0, illegal=0.
  - All enables deassert immediately during reset.
  - Reset mid-access abandons the access: mem_write/mem_read drop asynchronously and no register or PC update occurs.
- Output decoding:
  - Moore outputs, except that pc_write and ir_write in FETCH are gated by mem_ready, and pc_write in BEQ is gated by zero.
  - Unlisted outputs are 0; alu_ctrl defaults to add.
- States (encoding) and actions:
  - FETCH(0): adr_src=0, mem_read=1, a=00, b=10, add, result_src=10. Stay while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - DECODE(1): a=01, b=01, add (branch target into ALUOut). Next state by opcode and funct:
    - 0000011 with funct3=010 -> MEMADR
    - 0100011 with funct3=010 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 with funct3=000 -> BEQ
    - 0000000 with NOP_ZERO=1 -> FETCH, retired++
    - anything else -> ILLEGAL
  - R-type legal funct: funct3 000 (add; sub if funct7_5=1), 111 and, 110 or. Any other funct3 -> ILLEGAL.
  - I-type legal funct3: 000 addi, 111 andi, 110 ori. Others -> ILLEGAL.
  - MEMADR(2): a=10, b=01, add. Go to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD(3): adr_src=1, mem_read=1. Stay until mem_ready, then go to MEMWB.
  - MEMWB(4): result_src=01, reg_write=1, retired++, go to FETCH.
  - MEMWRITE(5): adr_src=1, mem_write=1, held until mem_ready. On mem_ready: retired++, go to FETCH.
  - EXECR(6): a=10, b=00, alu_ctrl from funct, go to ALUWB.
  - EXECI(7): a=10, b=01, alu_ctrl from funct3, go to ALUWB.
  - ALUWB(8): result_src=00, reg_write=1, retired++, go to FETCH.
  - BEQ(9): a=10, b=00, sub, result_src=00, pc_write=zero, retired++, go to FETCH.
  - ILLEGAL(10): illegal=1. Absorbing state: no enables asserted, leaves only on reset.
  - Encodings 11-15 are unreachable; if entered, go to ILLEGAL.
- Latency with mem_ready tied high:
  - NOP: 2 cycles
  - beq: 3 cycles
  - R-type, I-type, sw: 4 cycles
  - lw: 5 cycles
  - Each mem_ready=0 cycle adds one cycle.
- retired wraps modulo 2^CNT_W. It increments exactly once per completed instruction and never in ILLEGAL.
- mem_ready is ignored in states that do not access memory.

Test Plan:
1. Reset, mem_ready=1, feed add x13,x16,x25 (0x019806B3).
   -> Visits states 0,1,6,8,0; alu_ctrl=000 in EXECR; reg_write=1 only in ALUWB; retired=1.
2. Feed sub (0x403402B3), then beq x9,x9 (0x00948663) with zero=1.
   -> EXECR alu_ctrl=001; BEQ pc_write=1 in exactly one cycle. Repeat beq with zero=0 -> pc_write stays 0; retired=3 total.
3. Feed lw (0x01F2A403) with mem_ready low for 3 cycles in MEMREAD.
   -> Stays in state 3 for 4 cycles with adr_src=1 and mem_read=1; then MEMWB asserts result_src=01 and reg_write=1; 8 cycles total.
4. Feed sw (0x00F2A623); pulse rst_n low while in MEMWRITE.
   -> mem_write falls asynchronously; state=0, retired=0, no reg_write.
5. Feed 0x00000000, then 0x0000007F.
   -> NOP: 1→0 in 2 cycles, retired=1. Unknown opcode: illegal=1 and state=10 held for 20 cycles with all enables 0; clears only on rst_n.
6. With CNT_W=4, run 17 NOPs.
   -> retired wraps to 1.
